seg_scan_driver: RTL and testbench

Time-multiplexed driver for a bank of common-anode 7-segment digits. It scans one digit at a time and decodes each 4-bit hex nibble of a parametrised-width word. Data is held in a shadow register so each frame is tear-free. It adds a blanking guard against ghosting and a per-digit decimal point, and sits between the datapath debug word and the board display pins.

---
 rtl/seg_pkg.sv | 18 +
 rtl/seg_scan_driver_decoder.sv | 11 +
 rtl/seg_scan_driver.sv | 127 ++++++++++++
 tb/tb_seg_scan_driver.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: hex glyph table
// and all-off codes for segments and anodes.
package seg_pkg;

    localparam int MAX_DIGITS = 8;

    // Active-low gfedcba, entry 0 is glyph '0'
    localparam logic [0:15][6:0] SEG_TABLE = {
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

endpackage

// File: rtl/seg_scan_driver_decoder.sv
// Combinational hex nibble to active-low gfedcba segment decoder.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with tear-free shadow data.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] digit_idx,
    output logic                  frame_done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DW-1:0] BLANK_END = DW'(BLANK_CYC);
    localparam logic [DIGITS-1:0] AN_OFF = ANODE_OFF[DIGITS-1:0];

    logic [DW-1:0]         divider;
    logic                  load_pending;
    logic [4*DIGITS-1:0]   sh_data;
    logic [DIGITS-1:0]     sh_dp;
    logic [DIGITS-1:0]     an_nxt;
    logic [7:0]            seg_nxt;
    logic [4*DIGITS-1:0]   cur_data;
    logic [DIGITS-1:0]     cur_dp;
    logic [3:0]            nib;
    logic [6:0]            dec;
    logic                  term;
    logic                  wrap;
    logic                  load;
    logic                  in_blank;
    logic                  lz_blank;

    assign term     = (divider == DIV_LAST);
    assign wrap     = term && (digit_idx == IDX_LAST);
    assign load     = en && (load_pending || wrap);
    assign in_blank = (BLANK_CYC != 0) && (divider < BLANK_END);
    assign frame_done = en && wrap;

    // The first slot after a (re)load must already see the new word
    assign cur_data = load_pending ? data : sh_data;
    assign cur_dp   = load_pending ? dp   : sh_dp;
    assign nib      = cur_data[{digit_idx, 2'b00} +: 4];

    seg_decoder u_dec (
        .nibble (nib),
        .seg    (dec)
    );

`ifdef SEG_LZ_BLANK_EN
    logic [IW-1:0] lz_new;
    logic [IW-1:0] lz_q;
    logic [IW-1:0] lz_cur;

    always_comb begin
        lz_new = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (data[4*i +: 4] != 4'h0 || dp[i])
                lz_new = IW'(i);
        end
    end

    assign lz_cur   = load_pending ? lz_new : lz_q;
    assign lz_blank = (digit_idx > lz_cur);

    always_ff @(posedge clk) begin
        if (!rst_n)
            lz_q <= '0;
        else if (load)
            lz_q <= lz_new;
    end
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        an_nxt  = AN_OFF;
        seg_nxt = SEG_OFF;
        if (!in_blank && !lz_blank) begin
            an_nxt[digit_idx] = 1'b0;
            seg_nxt = {~cur_dp[digit_idx], dec};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            divider      <= '0;
            digit_idx    <= '0;
            load_pending <= 1'b1;
            sh_data      <= '0;
            sh_dp        <= '0;
            an           <= AN_OFF;
            seg          <= SEG_OFF;
        end else if (!en) begin
            divider      <= '0;
            digit_idx    <= '0;
            load_pending <= 1'b1;
            an           <= AN_OFF;
            seg          <= SEG_OFF;
        end else begin
            if (load) begin
                sh_data      <= data;
                sh_dp        <= dp;
                load_pending <= 1'b0;
            end
            if (term) begin
                divider   <= '0;
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
            end else begin
                divider <= divider + 1'b1;
            end
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (DIGITS=4, SCAN_DIV=4, BLANK_CYC=1).
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

    seg_scan_driver #(
        .DIGITS    (4),
        .SCAN_DIV  (4),
        .BLANK_CYC (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .data       (data),
        .dp         (dp),
        .seg        (seg),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en    = 1'b0;
        data  = '0;
        dp    = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (an !== 4'hF || seg !== 8'hFF || frame_done !== 1'b0 || digit_idx !== 2'd0) begin
                failures++;
                $display("FAIL reset[%0d] an=%h seg=%h fd=%b idx=%0d want an=F seg=FF fd=0 idx=0",
                         i, an, seg, frame_done, digit_idx);
            end
        end
    endtask

    // 3A10 with dp on digit 2; two full frames
    task automatic test_scan;
        logic [7:0] exp_seg [4];
        logic [3:0] exp_an;
        logic [7:0] exp_s;
        int s, pos;
        exp_seg = '{8'hC0, 8'hF9, 8'h08, 8'hB0};
        data  = 16'h3A10;
        dp    = 4'b0100;
        rst_n = 1'b1;
        en    = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            tick();
            s   = ((n - 1) / 4) % 4;
            pos = (n - 1) % 4;
            exp_an = (pos == 0) ? 4'hF : ~(4'b0001 << s);
            exp_s  = (pos == 0) ? 8'hFF : exp_seg[s];
            checks++;
            if (an !== exp_an || seg !== exp_s) begin
                failures++;
                $display("FAIL scan[%0d] an=%h seg=%h want an=%h seg=%h", n, an, seg, exp_an, exp_s);
            end
            checks++;
            if (frame_done !== ((n % 16) == 15) || digit_idx !== 2'((n / 4) % 4)) begin
                failures++;
                $display("FAIL scan_ctl[%0d] fd=%b idx=%0d want fd=%b idx=%0d",
                         n, frame_done, digit_idx, (n % 16) == 15, (n / 4) % 4);
            end
        end
    endtask

    task automatic test_tear_free;
        logic [7:0] exp_seg [4];
        logic [3:0] exp_an;
        logic [7:0] exp_s;
        int s, pos;
        exp_seg = '{8'hC0, 8'hF9, 8'h08, 8'hB0};
        for (int n = 1; n <= 32; n++) begin
            tick();
            if (n == 5) begin
                data = 16'hFFFF;
                dp   = 4'hF;
            end
            s   = ((n - 1) / 4) % 4;
            pos = (n - 1) % 4;
            exp_an = (pos == 0) ? 4'hF : ~(4'b0001 << s);
            exp_s  = (pos == 0) ? 8'hFF : ((n <= 16) ? exp_seg[s] : 8'h0E);
            checks++;
            if (an !== exp_an || seg !== exp_s) begin
                failures++;
                $display("FAIL tear[%0d] an=%h seg=%h want an=%h seg=%h", n, an, seg, exp_an, exp_s);
            end
        end
    endtask

    task automatic test_enable;
        for (int n = 1; n <= 9; n++)
            tick();
        en   = 1'b0;
        data = 16'h1234;
        dp   = 4'h0;
        for (int n = 1; n <= 5; n++) begin
            tick();
            checks++;
            if (an !== 4'hF || seg !== 8'hFF || digit_idx !== 2'd0 || frame_done !== 1'b0) begin
                failures++;
                $display("FAIL en_off[%0d] an=%h seg=%h idx=%0d fd=%b want F FF 0 0",
                         n, an, seg, digit_idx, frame_done);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if (an !== 4'hF || seg !== 8'hFF || digit_idx !== 2'd0) begin
            failures++;
            $display("FAIL en_blank an=%h seg=%h idx=%0d want F FF 0", an, seg, digit_idx);
        end
        for (int n = 2; n <= 4; n++) begin
            tick();
            checks++;
            if (an !== 4'hE || seg !== 8'h99) begin
                failures++;
                $display("FAIL en_digit0[%0d] an=%h seg=%h want an=E seg=99", n, an, seg);
            end
        end
    endtask

    task automatic test_reset_mid;
        for (int n = 1; n <= 10; n++)
            tick();
        checks++;
        if (an !== 4'h7 || seg !== 8'hF9 || digit_idx !== 2'd3) begin
            failures++;
            $display("FAIL pre_rst an=%h seg=%h idx=%0d want 7 F9 3", an, seg, digit_idx);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (an !== 4'hF || seg !== 8'hFF || digit_idx !== 2'd0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst an=%h seg=%h idx=%0d fd=%b want F FF 0 0",
                     an, seg, digit_idx, frame_done);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (an !== 4'hF || digit_idx !== 2'd0) begin
            failures++;
            $display("FAIL rst_restart an=%h idx=%0d want F 0", an, digit_idx);
        end
        tick();
        checks++;
        if (an !== 4'hE || seg !== 8'h99) begin
            failures++;
            $display("FAIL rst_digit0 an=%h seg=%h want E 99", an, seg);
        end
    endtask

`ifdef SEG_LZ_BLANK_EN
    task automatic test_lz_blank;
        logic [3:0] exp_an;
        logic [7:0] exp_s;
        int s, pos;
        for (int k = 0; k < 2; k++) begin
            en = 1'b0;
            tick();
            data = (k == 0) ? 16'h0042 : 16'h0000;
            dp   = 4'h0;
            en   = 1'b1;
            for (int n = 1; n <= 16; n++) begin
                tick();
                s   = (n - 1) / 4;
                pos = (n - 1) % 4;
                exp_an = 4'hF;
                exp_s  = 8'hFF;
                if (pos != 0 && s == 0) begin
                    exp_an = 4'hE;
                    exp_s  = (k == 0) ? 8'hA4 : 8'hC0;
                end else if (pos != 0 && s == 1 && k == 0) begin
                    exp_an = 4'hD;
                    exp_s  = 8'h99;
                end
                checks++;
                if (an !== exp_an || seg !== exp_s) begin
                    failures++;
                    $display("FAIL lz[%0d][%0d] an=%h seg=%h want an=%h seg=%h",
                             k, n, an, seg, exp_an, exp_s);
                end
            end
        end
    endtask
`endif

    // an must never have more than one bit low
    always @(negedge clk) begin
        if (rst_n === 1'b1 && !$isunknown(an) && $countones(~an) > 1) begin
            failures++;
            $display("FAIL onehot an=%h want at most one low bit", an);
        end
    end

    initial begin
        test_reset();
        test_scan();
        test_tear_free();
        test_enable();
        test_reset_mid();
`ifdef SEG_LZ_BLANK_EN
        test_lz_blank();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
